// File: rtl/alu_pkg.sv
// Shared opcode map, sequencer state encoding and request screening for the ALU sequencer.
package alu_pkg;

    localparam int unsigned OP_ADD  = 0;
    localparam int unsigned OP_SUB  = 1;
    localparam int unsigned OP_MUL  = 2;
    localparam int unsigned OP_DIV  = 3;
    localparam int unsigned OP_MOD  = 4;
    localparam int unsigned OP_LAND = 5;
    localparam int unsigned OP_LOR  = 6;
    localparam int unsigned OP_AND  = 7;
    localparam int unsigned OP_OR   = 8;
    localparam int unsigned OP_XOR  = 9;
    localparam int unsigned OP_MAX  = OP_XOR;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_e;

    // Callers zero-extend op and b so one helper serves any operand width.
    function automatic logic is_illegal(input logic [31:0] op, input logic [31:0] b);
        return (op > OP_MAX) || (((op == OP_DIV) || (op == OP_MOD)) && (b == '0));
    endfunction

endpackage

// File: rtl/alu_req_sequencer_if.sv
// Request, ALU and result signal bundle; master is the environment side, slave the sequencer.
interface alu_req_sequencer_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned RES_W  = 6,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned TAG_W  = 2,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [OP_W-1:0]   req_op;
    logic [TAG_W-1:0]  req_tag;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_i;
    logic              alu_v;
    logic [RES_W-1:0]  alu_s;

    logic              res_valid;
    logic              res_ready;
    logic [RES_W-1:0]  res_data;
    logic [TAG_W-1:0]  res_tag;
    logic              res_err;

    logic [CNT_W-1:0]  fifo_count;

    modport master (
        output req_valid, req_a, req_b, req_op, req_tag, res_ready, alu_s,
        input  req_ready, alu_a, alu_b, alu_i, alu_v,
        input  res_valid, res_data, res_tag, res_err, fifo_count
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_tag, res_ready, alu_s,
        output req_ready, alu_a, alu_b, alu_i, alu_v,
        output res_valid, res_data, res_tag, res_err, fifo_count
    );

endinterface

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO with registered occupancy; head entry is visible on rdata.
module alu_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/alu_req_sequencer.sv
// Buffers tagged ALU requests, issues them one at a time to a registered ALU and
// returns each result (or a local error for screened requests) over a valid/ready port.
module alu_req_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned RES_W   = 6,
    parameter int unsigned OP_W    = 4,
    parameter int unsigned TAG_W   = 2,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    alu_req_sequencer_if.slave bus
);
    localparam int unsigned ENTRY_W = 2 * DATA_W + OP_W + TAG_W;
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned LAT_W   = $clog2(ALU_LAT + 1);

    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;

    logic [DATA_W-1:0]  head_a;
    logic [DATA_W-1:0]  head_b;
    logic [OP_W-1:0]    head_op;
    logic [TAG_W-1:0]   head_tag;
    logic               head_illegal;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  alu_a_q, alu_a_d;
    logic [DATA_W-1:0]  alu_b_q, alu_b_d;
    logic [OP_W-1:0]    alu_i_q, alu_i_d;
    logic               alu_v_q, alu_v_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [LAT_W-1:0]   wcnt_q, wcnt_d;
    logic               res_valid_q, res_valid_d;
    logic [RES_W-1:0]   res_data_q, res_data_d;
    logic [TAG_W-1:0]   res_tag_q, res_tag_d;
    logic               res_err_q, res_err_d;

    assign fifo_wdata = {bus.req_tag, bus.req_op, bus.req_b, bus.req_a};
    assign {head_tag, head_op, head_b, head_a} = fifo_rdata;
    assign head_illegal = is_illegal(32'(head_op), 32'(head_b));

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.req_valid),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_i_d     = alu_i_q;
        alu_v_d     = alu_v_q;
        tag_d       = tag_q;
        wcnt_d      = wcnt_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_tag_d   = res_tag_q;
        res_err_d   = res_err_q;
        fifo_pop    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head_illegal) begin
                        // Screened locally: the ALU never sees this request.
                        res_data_d  = '0;
                        res_err_d   = 1'b1;
                        res_tag_d   = head_tag;
                        res_valid_d = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        alu_a_d = head_a;
                        alu_b_d = head_b;
                        alu_i_d = head_op;
                        alu_v_d = 1'b1;
                        tag_d   = head_tag;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                alu_v_d = 1'b0;
                wcnt_d  = LAT_W'(ALU_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                if (wcnt_q == LAT_W'(1)) begin
                    res_data_d  = bus.alu_s;
                    res_err_d   = 1'b0;
                    res_tag_d   = tag_q;
                    res_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    wcnt_d = wcnt_q - LAT_W'(1);
                end
            end
            HOLD: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_i_q     <= '0;
            alu_v_q     <= 1'b0;
            tag_q       <= '0;
            wcnt_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_tag_q   <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_i_q     <= alu_i_d;
            alu_v_q     <= alu_v_d;
            tag_q       <= tag_d;
            wcnt_q      <= wcnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_tag_q   <= res_tag_d;
            res_err_q   <= res_err_d;
        end
    end

    assign bus.req_ready  = !fifo_full;
    assign bus.fifo_count = fifo_count;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_i      = alu_i_q;
    assign bus.alu_v      = alu_v_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_tag    = res_tag_q;
    assign bus.res_err    = res_err_q;

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Directed scoreboard bench for alu_req_sequencer with ALU models of latency 1 and 3.
module tb_alu_req_sequencer;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned RES_W  = 6;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned TAG_W  = 2;
    localparam int unsigned DEPTH  = 4;

    typedef struct packed {
        logic [RES_W-1:0] data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    alu_req_sequencer_if #(.DATA_W(DATA_W), .RES_W(RES_W), .OP_W(OP_W), .TAG_W(TAG_W),
                           .DEPTH(DEPTH)) bus1 ();
    alu_req_sequencer_if #(.DATA_W(DATA_W), .RES_W(RES_W), .OP_W(OP_W), .TAG_W(TAG_W),
                           .DEPTH(DEPTH)) bus3 ();

    alu_req_sequencer #(.DATA_W(DATA_W), .RES_W(RES_W), .OP_W(OP_W), .TAG_W(TAG_W),
                        .DEPTH(DEPTH), .ALU_LAT(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    alu_req_sequencer #(.DATA_W(DATA_W), .RES_W(RES_W), .OP_W(OP_W), .TAG_W(TAG_W),
                        .DEPTH(DEPTH), .ALU_LAT(3)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    function automatic logic [RES_W-1:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                               input logic [3:0] op);
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] r;
        x = {4'b0, a};
        y = {4'b0, b};
        case (op)
            4'd0: r = x + y;
            4'd1: r = x - y;
            4'd2: r = x * y;
            4'd3: r = (y != 0) ? x / y : 8'd0;
            4'd4: r = (y != 0) ? x % y : 8'd0;
            4'd5: r = {7'b0, (x != 0) && (y != 0)};
            4'd6: r = {7'b0, (x != 0) || (y != 0)};
            4'd7: r = x & y;
            4'd8: r = x | y;
            4'd9: r = x ^ y;
            default: r = 8'd0;
        endcase
        return r[RES_W-1:0];
    endfunction

    // Registered ALU models: one stage for dut1, three stages for dut3.
    logic [RES_W-1:0] s1 = '0;
    logic [RES_W-1:0] p0 = '0;
    logic [RES_W-1:0] p1 = '0;
    logic [RES_W-1:0] p2 = '0;
    always_ff @(posedge clk) begin
        if (bus1.alu_v) s1 <= alu_f(bus1.alu_a, bus1.alu_b, bus1.alu_i);
        if (bus3.alu_v) p0 <= alu_f(bus3.alu_a, bus3.alu_b, bus3.alu_i);
        p1 <= p0;
        p2 <= p1;
    end
    assign bus1.alu_s = s1;
    assign bus3.alu_s = p2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one request on bus1; pushes the expected response once accepted.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                        input logic [1:0] tag, input logic [5:0] d, input logic e,
                        input bit expect_res);
        int n = 0;
        bus1.req_a     = a;
        bus1.req_b     = b;
        bus1.req_op    = op;
        bus1.req_tag   = tag;
        bus1.req_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus1.req_ready) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: req_ready stayed 0 for %0d cycles", n);
                bus1.req_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        if (expect_res) sbq.push_back('{data: d, tag: tag, err: e});
        #1 bus1.req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sbq.size() != 0 || bus1.res_valid) && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results still expected", sbq.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Result monitor: compares every handshake against the scoreboard and checks hold stability.
    initial begin
        exp_t e;
        bit   held = 1'b0;
        logic [RES_W-1:0] hd_data = '0;
        logic [TAG_W-1:0] hd_tag = '0;
        logic             hd_err = 1'b0;
        forever begin
            @(negedge clk);
            if (bus1.res_valid) begin
                if (held) begin
                    chk("hold_data", 32'(bus1.res_data), 32'(hd_data));
                    chk("hold_tag", 32'(bus1.res_tag), 32'(hd_tag));
                    chk("hold_err", 32'(bus1.res_err), 32'(hd_err));
                end
                hd_data = bus1.res_data;
                hd_tag  = bus1.res_tag;
                hd_err  = bus1.res_err;
                if (bus1.res_ready) begin
                    held = 1'b0;
                    checks++;
                    if (sbq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_result: data %0d tag %0d with none expected",
                                 bus1.res_data, bus1.res_tag);
                    end else begin
                        e = sbq.pop_front();
                        checks--;
                        chk("res_data", 32'(bus1.res_data), 32'(e.data));
                        chk("res_tag", 32'(bus1.res_tag), 32'(e.tag));
                        chk("res_err", 32'(bus1.res_err), 32'(e.err));
                    end
                end else begin
                    held = 1'b1;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    // alu_v must be a single-cycle pulse per issued op.
    initial begin
        logic prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (bus1.alu_v) begin
                pulses++;
                chk("alu_v_single_cycle", 32'(prev_v), 32'd0);
            end
            prev_v = bus1.alu_v;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0_cnt;
        int n;
        rst = 1'b1;
        bus1.req_valid = 1'b0; bus1.req_a = '0; bus1.req_b = '0; bus1.req_op = '0;
        bus1.req_tag = '0; bus1.res_ready = 1'b1;
        bus3.req_valid = 1'b0; bus3.req_a = '0; bus3.req_b = '0; bus3.req_op = '0;
        bus3.req_tag = '0; bus3.res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_req_ready", 32'(bus1.req_ready), 32'd1);
        chk("rst_alu_v", 32'(bus1.alu_v), 32'd0);
        chk("rst_alu_abi", 32'({bus1.alu_a, bus1.alu_b, bus1.alu_i}), 32'd0);
        chk("rst_res_valid", 32'(bus1.res_valid), 32'd0);
        chk("rst_res_fields", 32'({bus1.res_data, bus1.res_tag, bus1.res_err}), 32'd0);
        chk("rst_fifo_count", 32'(bus1.fifo_count), 32'd0);
        @(posedge clk);
        #1;

        // Single add with latency profile: alu_v E1-E2, res_valid at E3
        send(4'd3, 4'd5, 4'd0, 2'd1, 6'd8, 1'b0, 1'b1);
        @(negedge clk); chk("lat_alu_v_e0", 32'(bus1.alu_v), 32'd0);
        @(negedge clk); chk("lat_alu_v_e1", 32'(bus1.alu_v), 32'd1);
        @(negedge clk); chk("lat_alu_v_e2", 32'(bus1.alu_v), 32'd0);
        chk("lat_res_valid_e2", 32'(bus1.res_valid), 32'd0);
        @(negedge clk); chk("lat_res_valid_e3", 32'(bus1.res_valid), 32'd1);
        wait_drain();

        // Back-to-back sub (wraps) and mul (truncates)
        send(4'd2, 4'd5, 4'd1, 2'd2, 6'd61, 1'b0, 1'b1);
        send(4'd15, 4'd15, 4'd2, 2'd3, 6'd33, 1'b0, 1'b1);
        wait_drain();

        // Screened requests: div by zero and opcode 12
        p0_cnt = pulses;
        send(4'd9, 4'd0, 4'd3, 2'd2, 6'd0, 1'b1, 1'b1);
        @(negedge clk); chk("ill_res_valid_e0", 32'(bus1.res_valid), 32'd0);
        @(negedge clk); chk("ill_res_valid_e1", 32'(bus1.res_valid), 32'd1);
        @(posedge clk); #1;
        send(4'd7, 4'd3, 4'd12, 2'd3, 6'd0, 1'b1, 1'b1);
        wait_drain();
        chk("ill_no_alu_v", 32'(pulses - p0_cnt), 32'd0);

        // Backpressure: fill the FIFO while a result is held
        bus1.res_ready = 1'b0;
        send(4'd1, 4'd1, 4'd0, 2'd0, 6'd2, 1'b0, 1'b1);
        send(4'd4, 4'd3, 4'd1, 2'd1, 6'd1, 1'b0, 1'b1);
        send(4'd3, 4'd3, 4'd2, 2'd2, 6'd9, 1'b0, 1'b1);
        send(4'd14, 4'd3, 4'd3, 2'd3, 6'd4, 1'b0, 1'b1);
        send(4'd13, 4'd4, 4'd4, 2'd0, 6'd1, 1'b0, 1'b1);
        bus1.req_a = 4'd5; bus1.req_b = 4'd5; bus1.req_op = 4'd0; bus1.req_tag = 2'd1;
        bus1.req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("full_req_ready", 32'(bus1.req_ready), 32'd0);
        end
        chk("full_fifo_count", 32'(bus1.fifo_count), 32'd4);
        chk("full_res_held", 32'({bus1.res_valid, bus1.res_tag}), 32'({1'b1, 2'd0}));
        @(posedge clk);
        #1 bus1.req_valid = 1'b0;
        bus1.res_ready = 1'b1;
        wait_drain();

        // Reset during WAIT with two requests queued
        send(4'd1, 4'd2, 4'd0, 2'd1, 6'd0, 1'b0, 1'b0);
        send(4'd2, 4'd2, 4'd0, 2'd2, 6'd0, 1'b0, 1'b0);
        send(4'd3, 4'd2, 4'd0, 2'd3, 6'd0, 1'b0, 1'b0);
        chk("mid_fifo_count", 32'(bus1.fifo_count), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("mid_rst_alu_v", 32'(bus1.alu_v), 32'd0);
        chk("mid_rst_res_valid", 32'(bus1.res_valid), 32'd0);
        chk("mid_rst_fifo_count", 32'(bus1.fifo_count), 32'd0);
        chk("mid_rst_req_ready", 32'(bus1.req_ready), 32'd1);
        repeat (10) @(posedge clk);
        #1 chk("mid_rst_quiet", 32'(bus1.res_valid), 32'd0);

        // Recovery after reset
        send(4'd6, 4'd7, 4'd9, 2'd2, 6'd1, 1'b0, 1'b1);
        wait_drain();
        chk("alu_v_total", 32'(pulses), 32'd10);

        // ALU_LAT=3: mod 12 % 4, result five edges after acceptance
        bus3.req_a = 4'd12; bus3.req_b = 4'd4; bus3.req_op = 4'd4; bus3.req_tag = 2'd1;
        bus3.req_valid = 1'b1;
        @(negedge clk);
        chk("lat3_req_ready", 32'(bus3.req_ready), 32'd1);
        @(posedge clk);
        #1 bus3.req_valid = 1'b0;
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1 n++;
            if (bus3.res_valid) break;
        end
        chk("lat3_latency", 32'(n), 32'd5);
        chk("lat3_res_data", 32'(bus3.res_data), 32'd0);
        chk("lat3_res_err", 32'(bus3.res_err), 32'd0);
        chk("lat3_res_tag", 32'(bus3.res_tag), 32'd1);
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_req_sequencer.md
Name: alu_req_sequencer

Overview:
Initiator-side companion to the team's registered ALU. It accepts tagged operation requests over a valid/ready handshake and buffers them in a small FIFO. It drives the ALU operand/opcode/valid inputs one operation at a time, captures the ALU's registered result after the fixed ALU latency, and returns it with its tag over a valid/ready result handshake. Illegal opcodes and divide/modulo-by-zero requests are screened locally and never reach the ALU.

Parameters:
DATA_W, 4, operand width (ALU a/b width)
RES_W, 6, result width (ALU s width)
OP_W, 4, opcode width (ALU i width)
TAG_W, 2, request tag width carried to the result
DEPTH, 4, request FIFO depth (power of two)
ALU_LAT, 1, cycles from the ALU-sampling edge until alu_s is stable; ALU_LAT >= 1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_a  in  DATA_W  operand a
req_b  in  DATA_W  operand b
req_op  in  OP_W  opcode 0..9 (add, sub, mul, div, mod, land, lor, and, or, xor)
req_tag  in  TAG_W  caller tag
alu_a  out  DATA_W  to ALU a
alu_b  out  DATA_W  to ALU b
alu_i  out  OP_W  to ALU i
alu_v  out  1  to ALU v, one-cycle pulse per issued op
alu_s  in  RES_W  from ALU s
res_valid  out  1  result present
res_ready  in  1  result consumed when res_valid && res_ready
res_data  out  RES_W  result
res_tag  out  TAG_W  tag of the originating request
res_err  out  1  1 = illegal opcode or b==0 on div/mod; res_data = 0
fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs registered. req_ready=1 once reset is released, alu_a/b/i=0, alu_v=0, res_valid=0, res_data=0, res_tag=0, res_err=0, fifo_count=0. FSM state is IDLE.
- FIFO:
  - req_ready = !full, based on the registered count.
  - Push on the handshake. Pop only when IDLE dispatches.
  - Push and pop in the same cycle leave the count unchanged.
  - No push when full. Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE, FIFO non-empty, head legal: pop the head; load alu_a/b/i and the pending tag; set alu_v=1; go to ISSUE.
  - IDLE, FIFO non-empty, head illegal (op > 9, or op in {3,4} with b==0): pop the head; res_data=0, res_err=1, res_tag=tag, res_valid=1; go to HOLD. alu_v stays 0.
  - IDLE, FIFO empty: stay in IDLE.
  - ISSUE lasts exactly one cycle with alu_v=1; the ALU samples at its closing edge. Then alu_v=0, load wait counter = ALU_LAT, go to WAIT.
  - WAIT: decrement the counter each cycle. On the edge where the counter reaches 1: res_data=alu_s, res_err=0, res_valid=1; go to HOLD.
  - HOLD: res_* are held stable while res_valid && !res_ready. On the handshake edge: res_valid=0; go to IDLE.
- alu_a/b/i keep their last values while alu_v=0.
- Latency with ALU_LAT=1 and an idle block:
  - Request accepted at edge E0.
  - alu_v high between E1 and E2.
  - res_valid rises at E3.
  - Illegal requests: res_valid rises at E1.
- Throughput: at most one op in flight. A new dispatch occurs no earlier than the edge after the result handshake.
- Arithmetic: no width handling is done here. res_data is alu_s verbatim, so truncation and wrap follow the ALU (sub wraps mod 2^RES_W, mul truncates to RES_W).
- Backpressure: the FIFO keeps accepting requests during HOLD until full.
- Reset mid-operation:
  - alu_v=0 on the next edge.
  - FIFO emptied; any in-flight or held result discarded.
  - No res_valid until a new request arrives.

Decomposition:
- Package alu_pkg:
  - opcode localparams: OP_ADD=0 through OP_XOR=9, OP_MAX=9
  - state encoding: IDLE, ISSUE, WAIT, HOLD
  - function is_illegal(op, b)
- One sub-module: alu_req_fifo, a parameterised synchronous FIFO (DEPTH, width DATA_W*2+OP_W+TAG_W) with count/full/empty outputs.

Test Plan:
- Push {a=3, b=5, op=0, tag=1}, res_ready=1, ALU attached -> alu_v pulses once at E1-E2, res_valid at E3, res_data=8, res_tag=1, res_err=0.
- Push {2,5,op=1} then {15,15,op=2} back-to-back -> results in order: 61 then 33 (225 mod 64). Each alu_v is a single-cycle pulse with no overlap.
- Push {9,0,op=3,tag=2} and {7,3,op=12,tag=3} -> two results, both res_err=1, res_data=0, tags 2 and 3. alu_v never asserted.
- res_ready=0, push 6 requests -> one result held stable in HOLD, fifo_count reaches 4, req_ready=0, 6th request not accepted. Raise res_ready -> remaining results drain in order with correct tags.
- Assert rst for 1 cycle during WAIT with 2 requests queued -> next edge: alu_v=0, res_valid=0, fifo_count=0, req_ready=1. No result ever emitted for the flushed requests.
- Single push of {12,4,op=4} with ALU_LAT=3 (ALU model delayed accordingly) -> res_valid rises 5 edges after acceptance, res_data=0, res_err=0.
